// File: rtl/fx_kpc_pkg.sv
// fx_kpc_pkg: shared state encoding and default sizing for the K-Port transfer controller
package fx_kpc_pkg;
   typedef enum logic [2:0] {IDLE, LATCH, SHIFT_LO, SHIFT_HI, DONE} kpc_state_t;
   localparam int KPC_NBITS    = 32;
   localparam int KPC_HALF_DIV = 16;
endpackage

// File: rtl/fx_kpc_div.sv
// fx_kpc_div: CE-qualified half-period tick generator
// Ports: i_clk/i_res clock and sync reset, i_ce clock enable, i_restart zeroes the count,
//        i_run enables counting, o_phase_done pulses on the HALF_DIV-th running CE tick.
module fx_kpc_div #(
   parameter int HALF_DIV = 16
) (
   input  logic i_clk,
   input  logic i_res,
   input  logic i_ce,
   input  logic i_restart,
   input  logic i_run,
   output logic o_phase_done
);
   localparam int CW = HALF_DIV > 1 ? $clog2(HALF_DIV) : 1;
   logic [CW-1:0] r_cnt;
   assign o_phase_done = i_ce && i_run && (r_cnt == CW'(HALF_DIV - 1));
   always_ff @(posedge i_clk)
      if (i_res || (i_ce && (i_restart || !i_run || o_phase_done))) r_cnt <= '0;
      else if (i_ce) r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/fx_kpc.sv
// fx_kpc: K-Port serial transfer controller sequencing the pad latch and shift-clock handshake
// Ports: i_clk/i_res clock and sync reset, i_ce clock enable, i_trg start pulse,
//        i_mode latch-before-shift, i_ios 1=read pad 0=drive pad, i_wdata word to send,
//        i_rd_ack clears o_end, o_busy/o_end status, o_rdata received word,
//        o_kp_latn/o_kp_clk/i_kp_di/o_kp_do/o_kp_oe pad interface.
module fx_kpc
   import fx_kpc_pkg::*;
#(
   parameter int NBITS    = KPC_NBITS,
   parameter int HALF_DIV = KPC_HALF_DIV
) (
   input  logic             i_clk,
   input  logic             i_res,
   input  logic             i_ce,
   input  logic             i_trg,
   input  logic             i_mode,
   input  logic             i_ios,
   input  logic [NBITS-1:0] i_wdata,
   input  logic             i_rd_ack,
   output logic             o_busy,
   output logic             o_end,
   output logic [NBITS-1:0] o_rdata,
   output logic             o_kp_latn,
   output logic             o_kp_clk,
   input  logic             i_kp_di,
   output logic             o_kp_do,
   output logic             o_kp_oe
);
   localparam int BW = NBITS > 1 ? $clog2(NBITS) : 1;
   kpc_state_t       r_state;
   logic             r_start, r_mode, r_ios, r_busy, r_end, r_latn, r_kclk, r_do, r_oe;
   logic [NBITS-1:0] r_sh, r_rdata;
   logic [BW-1:0]    r_bit;
   logic             w_run, w_done, w_last, w_to_lo;
   fx_kpc_div #(.HALF_DIV(HALF_DIV)) u_div (
      .i_clk(i_clk),
      .i_res(i_res),
      .i_ce(i_ce),
      .i_restart(r_start),
      .i_run(w_run),
      .o_phase_done(w_done)
   );
   // r_start adds the one tick between accepting TRG and raising BUSY.
   // Every path into SHIFT_LO shares one entry action, so it is decoded once here.
   always_comb begin
      w_run   = r_state inside {LATCH, SHIFT_LO, SHIFT_HI};
      w_last  = r_bit == BW'(NBITS - 1);
      w_to_lo = (r_state == IDLE && r_start && !r_mode) ||
                (w_done && (r_state == LATCH || (r_state == SHIFT_HI && !w_last)));
   end
   always_ff @(posedge i_clk) begin
      if (i_res) begin
         r_state <= IDLE;
         r_start <= 1'b0;
         r_mode  <= 1'b0;
         r_ios   <= 1'b0;
         r_busy  <= 1'b0;
         r_end   <= 1'b0;
         r_latn  <= 1'b1;
         r_kclk  <= 1'b1;
         r_do    <= 1'b0;
         r_oe    <= 1'b0;
         r_sh    <= '0;
         r_rdata <= '0;
         r_bit   <= '0;
      end else if (i_ce) begin
         if (i_rd_ack) r_end <= 1'b0;
         if (w_to_lo) begin
            r_state <= SHIFT_LO;
            r_latn  <= 1'b1;
            r_kclk  <= 1'b0;
            r_do    <= r_sh[0];
            r_sh    <= r_sh >> 1;
            r_oe    <= ~r_ios;
         end
         case (r_state)
            IDLE:
               if (r_start) begin
                  r_start <= 1'b0;
                  r_busy  <= 1'b1;
                  if (r_mode) begin
                     r_state <= LATCH;
                     r_latn  <= 1'b0;
                  end
               end else if (i_trg) begin
                  r_start <= 1'b1;
                  r_mode  <= i_mode;
                  r_ios   <= i_ios;
                  r_sh    <= i_wdata;
               end
            LATCH: ;
            SHIFT_LO:
               if (w_done) begin
                  r_state <= SHIFT_HI;
                  r_kclk  <= 1'b1;
                  if (r_ios) r_rdata <= {i_kp_di, r_rdata[NBITS-1:1]};
               end
            SHIFT_HI:
               if (w_done) begin
                  r_bit <= w_last ? '0 : r_bit + 1'b1;
                  if (w_last) r_state <= DONE;
               end
            DONE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_end   <= 1'b1;
               r_oe    <= 1'b0;
               r_do    <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign o_busy    = r_busy;
   assign o_end     = r_end;
   assign o_rdata   = r_rdata;
   assign o_kp_latn = r_latn;
   assign o_kp_clk  = r_kclk;
   assign o_kp_do   = r_do;
   assign o_kp_oe   = r_oe;
endmodule
